// File: rtl/encoder_spi.sv
// encoder_spi: serial encoder frame receiver clocked by sck.
// A low cs sample in IDLE starts a DATA_WIDTH-bit MSB-first capture. The
// previously captured word is echoed on miso during the frame for loopback.
module encoder_spi #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  sck,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  din,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] encoder_val_full,
    output logic                  data_valid
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SR_W  = DATA_WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    // Only DATA_WIDTH-1 bits need storing; the last bit comes straight from din.
    logic [SR_W-1:0]   shreg;
    // Remaining echo bits of the previous word, next one to send in the MSB.
    logic [SR_W-1:0]   echo;

    // Frame FSM: capture, completion pulse and miso echo, all registered.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            shreg            <= '0;
            echo             <= '0;
            miso             <= 1'b0;
            encoder_val_full <= '0;
            data_valid       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        miso  <= encoder_val_full[DATA_WIDTH-1];
                        echo  <= encoder_val_full[SR_W-1:0];
                    end
                end
                SHIFT: begin
                    shreg <= SR_W'({shreg, din});
                    if (cnt != CNT_W'(DATA_WIDTH)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        encoder_val_full <= {shreg, din};
                        data_valid       <= 1'b1;
                        miso             <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        miso <= echo[SR_W-1];
                        echo <= SR_W'({echo, 1'b0});
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_spi.sv
// Directed self-checking bench for encoder_spi (8-bit and 12-bit instances).
`timescale 1ns/1ps
module tb_encoder_spi;

    logic        sck;
    logic        rst_n;
    logic        cs8, din8, miso8, dv8;
    logic [7:0]  val8;
    logic        cs12, din12, miso12, dv12;
    logic [11:0] val12;

    int checks = 0;
    int errors = 0;

    encoder_spi #(.DATA_WIDTH(8)) dut8 (
        .sck(sck), .rst_n(rst_n), .cs(cs8), .din(din8),
        .miso(miso8), .encoder_val_full(val8), .data_valid(dv8)
    );

    encoder_spi #(.DATA_WIDTH(12)) dut12 (
        .sck(sck), .rst_n(rst_n), .cs(cs12), .din(din12),
        .miso(miso12), .encoder_val_full(val12), .data_valid(dv12)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit frame: checks miso echo of prev, capture of bits, one-cycle valid.
    task automatic frame8(input logic [7:0] bits, input logic [7:0] prev, input bit glitch);
        cs8 = 1'b0;
        tick();                     // edge S
        cs8 = 1'b1;
        chk("f8_miso_S", 32'(miso8), 32'(prev[7]));
        chk("f8_dv_S", 32'(dv8), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            din8 = bits[8-k];
            if (glitch && (k == 3 || k == 5)) cs8 = 1'b0;
            else cs8 = 1'b1;
            tick();                 // edge S+k
            if (k < 8) begin
                chk("f8_miso", 32'(miso8), 32'(prev[7-k]));
                chk("f8_dv_mid", 32'(dv8), 32'd0);
                chk("f8_hold", 32'(val8), 32'(prev));
            end else begin
                chk("f8_dv_end", 32'(dv8), 32'd1);
                chk("f8_val", 32'(val8), 32'(bits));
                chk("f8_miso_end", 32'(miso8), 32'd0);
            end
        end
        cs8  = 1'b1;
        din8 = 1'b0;
        tick();                     // edge S+9
        chk("f8_dv_fall", 32'(dv8), 32'd0);
        chk("f8_val_held", 32'(val8), 32'(bits));
    endtask

    initial begin
        rst_n = 1'b0;
        cs8 = 1'b1; din8 = 1'b0;
        cs12 = 1'b1; din12 = 1'b0;
        tick();
        tick();
        chk("rst_val", 32'(val8), 32'd0);
        chk("rst_dv", 32'(dv8), 32'd0);
        chk("rst_miso", 32'(miso8), 32'd0);
        chk("rst_val12", 32'(val12), 32'd0);
        rst_n = 1'b1;

        // Idle with cs high: nothing captured.
        din8 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_dv", 32'(dv8), 32'd0);
            chk("idle_miso", 32'(miso8), 32'd0);
        end
        chk("idle_val", 32'(val8), 32'd0);

        // All ones, then 0xA6 (with cs glitches inside), then zeros echoing 0xA6.
        frame8(8'hFF, 8'h00, 1'b0);
        frame8(8'hA6, 8'hFF, 1'b1);
        frame8(8'h00, 8'hA6, 1'b0);

        // cs held low: frames start at edges 1,10,19,28; valid at 9,18,27.
        cs8 = 1'b0;
        din8 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk("cont_dv", 32'(dv8), (c == 9 || c == 18 || c == 27) ? 32'd1 : 32'd0);
        end
        cs8 = 1'b1;
        for (int c = 31; c <= 37; c++) begin
            tick();
            chk("cont_tail_dv", 32'(dv8), (c == 36) ? 32'd1 : 32'd0);
        end
        chk("cont_val", 32'(val8), 32'hFF);

        // Reset at bit 4 of a frame discards it.
        cs8 = 1'b0;
        din8 = 1'b1;
        tick();                     // edge S
        cs8 = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 32'(val8), 32'd0);
        chk("mid_rst_dv", 32'(dv8), 32'd0);
        chk("mid_rst_miso", 32'(miso8), 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mid_rst_hold_dv", 32'(dv8), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_dv", 32'(dv8), 32'd0);
        frame8(8'h3C, 8'h00, 1'b0);

        // 12-bit instance: all ones.
        cs12 = 1'b0;
        din12 = 1'b1;
        tick();                     // edge S
        cs12 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("w12_dv", 32'(dv12), (k == 12) ? 32'd1 : 32'd0);
        end
        chk("w12_val", 32'(val12), 32'hFFF);
        tick();
        chk("w12_dv_fall", 32'(dv12), 32'd0);
        chk("w12_val_held", 32'(val12), 32'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
